// File: rtl/read_s_mem_by_index_pkg.sv
// read_s_mem_by_index_pkg
// Shared RC4 S-memory definitions: memory geometry, the read-pass state
// encoding and a small compare helper. The S memory writer FSMs use the
// same geometry constants, so keep them here rather than in a module.
//
// Contents:
//   S_MEM_DEPTH      number of S entries (256)
//   S_MEM_LAST_ADDR  highest S index (255)
//   S_ADDR_CNT_W     width of a pass address counter (one spare MSB)
//   s_read_state_t   state code type for the S read-pass FSM
//   ST_*             state codes
//   is_index_mismatch()  true when a byte differs from its own index
package read_s_mem_by_index_pkg;

  localparam int S_MEM_DEPTH     = 256;
  localparam int S_MEM_LAST_ADDR = S_MEM_DEPTH - 1;

  // One bit wider than an address so a counter can never silently wrap
  // back onto index 0 inside a pass.
  localparam int S_ADDR_CNT_W = $clog2(S_MEM_DEPTH) + 1;

  typedef logic [2:0] s_read_state_t;

  localparam s_read_state_t ST_IDLE    = 3'd0;
  localparam s_read_state_t ST_ISSUE   = 3'd1;
  localparam s_read_state_t ST_WAIT    = 3'd2;
  localparam s_read_state_t ST_CAPTURE = 3'd3;
  localparam s_read_state_t ST_OUTPUT  = 3'd4;
  localparam s_read_state_t ST_FINISH  = 3'd5;

  // After key scheduling is reset, S must hold the identity permutation;
  // this is the per-entry test for that.
  function automatic logic is_index_mismatch(input logic [7:0] data,
                                             input logic [7:0] index);
    return data != index;
  endfunction

endpackage

// File: rtl/read_s_mem_by_index_if.sv
// read_s_mem_by_index_if
// Valid/ready byte stream carrying the bytes read out of S memory.
//
// Signals:
//   byte_out    byte read from S[address]
//   byte_valid  byte_out is valid; held until accepted
//   byte_ready  consumer accepts; transfer when valid and ready on a posedge
//
// Modports:
//   master  producer side (the S reader)
//   slave   consumer side
interface read_s_mem_by_index_if;

  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);

endinterface

// File: rtl/read_s_mem_by_index.sv
// read_s_mem_by_index
// Reads all 256 entries of the RC4 S memory in index order and streams
// them out one byte at a time over a valid/ready handshake. Optionally
// checks every entry against its own index (identity permutation) and
// records the first offending index of the pass.
//
// Parameters:
//   RAM_LATENCY       cycles from address_out change to valid data_in (1..3)
//
// Ports:
//   clk               sole clock
//   reset             synchronous, active-high
//   start             launch a pass (accepted in IDLE or FINISH only)
//   check_en          sampled with start; enables the identity check
//   address_out       S memory read address
//   data_in           S memory read data
//   write_enable_out  always 0, this block only reads S
//   byte_if           master side of the output byte stream
//   mismatch          sticky flag: identity check failed in this pass
//   mismatch_addr     index of the first failing entry in this pass
//   read_done         pass complete, high while in FINISH
module read_s_mem_by_index
  import read_s_mem_by_index_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          check_en,
  output logic [7:0]                    address_out,
  input  logic [7:0]                    data_in,
  output logic                          write_enable_out,
  read_s_mem_by_index_if.master         byte_if,
  output logic                          mismatch,
  output logic [7:0]                    mismatch_addr,
  output logic                          read_done
);

  s_read_state_t           state_q, state_d;
  logic [S_ADDR_CNT_W-1:0] counter_q, counter_d;
  logic [1:0]              lat_q, lat_d;
  logic                    check_q, check_d;
  logic [7:0]              byte_q, byte_d;
  logic                    mismatch_q, mismatch_d;
  logic [7:0]              mm_addr_q, mm_addr_d;

  // The latency counter is loaded with RAM_LATENCY-1 so that WAIT lasts
  // exactly RAM_LATENCY cycles; it is two bits wide to cover 1..3.
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  localparam logic [S_ADDR_CNT_W-1:0] LAST_CNT = S_ADDR_CNT_W'(S_MEM_LAST_ADDR);

  // Next-state and datapath logic. One byte takes ISSUE + WAIT + CAPTURE
  // + OUTPUT, i.e. 3 + RAM_LATENCY cycles when the consumer never stalls.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    lat_d      = lat_q;
    check_d    = check_q;
    byte_d     = byte_q;
    mismatch_d = mismatch_q;
    mm_addr_d  = mm_addr_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d    = ST_ISSUE;
          counter_d  = '0;
          check_d    = check_en;
          mismatch_d = 1'b0;
          mm_addr_d  = 8'h00;
        end
      end

      ST_ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      ST_CAPTURE: begin
        byte_d  = data_in;
        state_d = ST_OUTPUT;
        // Only the first failing index of a pass is kept; the sticky flag
        // tells us whether one has already been recorded.
        if (check_q && is_index_mismatch(data_in, counter_q[7:0])) begin
          mismatch_d = 1'b1;
          if (!mismatch_q) begin
            mm_addr_d = counter_q[7:0];
          end
        end
      end

      ST_OUTPUT: begin
        if (byte_if.byte_ready) begin
          if (counter_q == LAST_CNT) begin
            state_d = ST_FINISH;
          end else begin
            counter_d = counter_q + 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything, so a pass
  // interrupted by reset issues no further reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      lat_q      <= 2'd0;
      check_q    <= 1'b0;
      byte_q     <= 8'h00;
      mismatch_q <= 1'b0;
      mm_addr_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      lat_q      <= lat_d;
      check_q    <= check_d;
      byte_q     <= byte_d;
      mismatch_q <= mismatch_d;
      mm_addr_q  <= mm_addr_d;
    end
  end

  // Outputs come straight from registered state; the counter only moves on
  // a transfer, so the address stays stable while a byte is being offered.
  assign address_out        = counter_q[7:0];
  assign write_enable_out   = 1'b0;
  assign byte_if.byte_out   = byte_q;
  assign byte_if.byte_valid = (state_q == ST_OUTPUT);
  assign mismatch           = mismatch_q;
  assign mismatch_addr      = mm_addr_q;
  assign read_done          = (state_q == ST_FINISH);

endmodule

// File: tb/tb_read_s_mem_by_index.sv
// tb_read_s_mem_by_index
// Directed bench for read_s_mem_by_index. Instance A uses RAM_LATENCY=1,
// instance B uses RAM_LATENCY=2; each has its own synchronous memory model
// and its own expected-byte queue drained by a monitor on the falling edge.
module tb_read_s_mem_by_index;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A (RAM_LATENCY = 1)
  logic       reset_a = 1'b1;
  logic       start_a = 1'b0;
  logic       check_en_a = 1'b0;
  logic [7:0] addr_a;
  logic [7:0] data_a;
  logic       we_a;
  logic       mismatch_a;
  logic [7:0] mm_addr_a;
  logic       done_a;
  logic [7:0] mem_a [256];
  logic [7:0] pipe_a = 8'h00;
  exp_t       exp_q_a [$];

  read_s_mem_by_index_if bif_a ();

  read_s_mem_by_index #(.RAM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .check_en(check_en_a),
    .address_out(addr_a), .data_in(data_a), .write_enable_out(we_a),
    .byte_if(bif_a), .mismatch(mismatch_a), .mismatch_addr(mm_addr_a),
    .read_done(done_a)
  );

  // Synchronous RAM: q follows the address one cycle later
  always @(posedge clk) pipe_a <= addr_a;
  assign data_a = mem_a[pipe_a];

  // Instance B (RAM_LATENCY = 2)
  logic       reset_b = 1'b1;
  logic       start_b = 1'b0;
  logic       check_en_b = 1'b0;
  logic [7:0] addr_b;
  logic [7:0] data_b;
  logic       we_b;
  logic       mismatch_b;
  logic [7:0] mm_addr_b;
  logic       done_b;
  logic [7:0] mem_b [256];
  logic [7:0] pipe_b1 = 8'h00;
  logic [7:0] pipe_b2 = 8'h00;
  exp_t       exp_q_b [$];
  int         last_xfer_b = -1;

  read_s_mem_by_index_if bif_b ();

  read_s_mem_by_index #(.RAM_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .check_en(check_en_b),
    .address_out(addr_b), .data_in(data_b), .write_enable_out(we_b),
    .byte_if(bif_b), .mismatch(mismatch_b), .mismatch_addr(mm_addr_b),
    .read_done(done_b)
  );

  always @(posedge clk) begin
    pipe_b1 <= addr_b;
    pipe_b2 <= pipe_b1;
  end
  assign data_b = mem_b[pipe_b2];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor A: every accepted byte must match the head of the queue
  always @(negedge clk) begin
    if (!reset_a && bif_a.byte_valid && bif_a.byte_ready) begin
      if (exp_q_a.size() == 0) begin
        checkOutput("a_unexpected_byte", {24'd0, addr_a}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q_a.pop_front();
        checkOutput("a_byte_addr", {24'd0, addr_a}, {24'd0, e.addr});
        checkOutput("a_byte_data", {24'd0, bif_a.byte_out}, {24'd0, e.data});
      end
    end
  end

  // Monitor B: also checks the spacing between consecutive transfers
  always @(negedge clk) begin
    if (!reset_b && bif_b.byte_valid && bif_b.byte_ready) begin
      if (exp_q_b.size() == 0) begin
        checkOutput("b_unexpected_byte", {24'd0, addr_b}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q_b.pop_front();
        checkOutput("b_byte_addr", {24'd0, addr_b}, {24'd0, e.addr});
        checkOutput("b_byte_data", {24'd0, bif_b.byte_out}, {24'd0, e.data});
      end
      if (last_xfer_b >= 0) begin
        checkOutput("b_interval", 32'(cyc - last_xfer_b), 32'd5);
      end
      last_xfer_b = cyc;
    end
  end

  // Queue the full expected pass for A, then pulse start for one cycle.
  // Called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic ck);
    for (int i = 0; i < 256; i++) begin
      exp_q_a.push_back('{addr: 8'(i), data: mem_a[i]});
    end
    check_en_a = ck;
    start_a    = 1'b1;
    @(posedge clk); #1;
    start_a    = 1'b0;
  endtask

  task automatic waitDone(input bit use_b, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!(use_b ? done_b : done_a) && cycles < 5000);
    if (!(use_b ? done_b : done_a)) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitAddrA(input logic [7:0] a);
    int n = 0;
    while (addr_a !== a && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (addr_a !== a) checkOutput("wait_addr_timeout", {24'd0, addr_a}, {24'd0, a});
  endtask

  task automatic waitValidA();
    int n = 0;
    while (bif_a.byte_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bif_a.byte_valid !== 1'b1) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  int cycles;

  initial begin
    bif_a.byte_ready = 1'b1;
    bif_b.byte_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(i) ^ 8'hA5;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, bif_a.byte_valid}, 32'd0);
    checkOutput("rst_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_mismatch", {31'd0, mismatch_a}, 32'd0);
    checkOutput("rst_mm_addr", {24'd0, mm_addr_a}, 32'd0);
    checkOutput("rst_addr", {24'd0, addr_a}, 32'd0);
    checkOutput("rst_byte", {24'd0, bif_a.byte_out}, 32'd0);
    checkOutput("rst_we", {31'd0, we_a}, 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(posedge clk); #1;

    // Pass 1: identity memory, check on, no stalls, 4 cycles per byte
    applyStimulus(1'b1);
    waitDone(1'b0, cycles);
    checkOutput("p1_cycles", 32'(cycles), 32'd1024);
    checkOutput("p1_mismatch", {31'd0, mismatch_a}, 32'd0);
    checkOutput("p1_done", {31'd0, done_a}, 32'd1);
    checkOutput("p1_valid_low", {31'd0, bif_a.byte_valid}, 32'd0);
    checkOutput("p1_queue_empty", 32'(exp_q_a.size()), 32'd0);

    // Pass 2: two bad entries, consumer stall at 0x10, mid-pass noise
    mem_a[8'h37] = 8'h00;
    mem_a[8'h80] = 8'h11;
    applyStimulus(1'b1);
    check_en_a = 1'b0;
    checkOutput("p2_done_cleared", {31'd0, done_a}, 32'd0);
    waitAddrA(8'h10);
    bif_a.byte_ready = 1'b0;
    waitValidA();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", {31'd0, bif_a.byte_valid}, 32'd1);
      checkOutput("stall_byte", {24'd0, bif_a.byte_out}, 32'h10);
      checkOutput("stall_addr", {24'd0, addr_a}, 32'h10);
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    bif_a.byte_ready = 1'b1;
    waitAddrA(8'h20);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    waitAddrA(8'h40);
    checkOutput("p2_mid_mismatch", {31'd0, mismatch_a}, 32'd1);
    checkOutput("p2_mid_mm_addr", {24'd0, mm_addr_a}, 32'h37);
    waitDone(1'b0, cycles);
    checkOutput("p2_mismatch", {31'd0, mismatch_a}, 32'd1);
    checkOutput("p2_mm_addr", {24'd0, mm_addr_a}, 32'h37);
    checkOutput("p2_queue_empty", 32'(exp_q_a.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("p2_hold_mm_addr", {24'd0, mm_addr_a}, 32'h37);
    checkOutput("p2_hold_done", {31'd0, done_a}, 32'd1);

    // Pass 3: restart from FINISH, scrambled S, check off
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'hFF;
    applyStimulus(1'b0);
    checkOutput("p3_done_cleared", {31'd0, done_a}, 32'd0);
    checkOutput("p3_mismatch_cleared", {31'd0, mismatch_a}, 32'd0);
    waitDone(1'b0, cycles);
    checkOutput("p3_cycles", 32'(cycles), 32'd1024);
    checkOutput("p3_mismatch", {31'd0, mismatch_a}, 32'd0);
    checkOutput("p3_done", {31'd0, done_a}, 32'd1);
    checkOutput("p3_queue_empty", 32'(exp_q_a.size()), 32'd0);

    // Pass 4: abort with reset at address 0x42, then a fresh pass
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
    applyStimulus(1'b1);
    waitAddrA(8'h42);
    reset_a = 1'b1;
    @(posedge clk); #1;
    exp_q_a.delete();
    checkOutput("rst_mid_valid", {31'd0, bif_a.byte_valid}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_mid_addr", {24'd0, addr_a}, 32'd0);
    checkOutput("rst_mid_byte", {24'd0, bif_a.byte_out}, 32'd0);
    reset_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_rst_idle_addr", {24'd0, addr_a}, 32'd0);
    checkOutput("post_rst_idle_valid", {31'd0, bif_a.byte_valid}, 32'd0);
    applyStimulus(1'b1);
    waitDone(1'b0, cycles);
    checkOutput("p5_cycles", 32'(cycles), 32'd1024);
    checkOutput("p5_mismatch", {31'd0, mismatch_a}, 32'd0);
    checkOutput("p5_queue_empty", 32'(exp_q_a.size()), 32'd0);

    // Instance B: two-cycle RAM, 5 cycles per byte
    checkOutput("b_rst_valid", {31'd0, bif_b.byte_valid}, 32'd0);
    checkOutput("b_rst_we", {31'd0, we_b}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      exp_q_b.push_back('{addr: 8'(i), data: mem_b[i]});
    end
    check_en_b = 1'b0;
    start_b    = 1'b1;
    @(posedge clk); #1;
    start_b    = 1'b0;
    waitDone(1'b1, cycles);
    checkOutput("b_cycles", 32'(cycles), 32'd1280);
    checkOutput("b_mismatch", {31'd0, mismatch_b}, 32'd0);
    checkOutput("b_done", {31'd0, done_b}, 32'd1);
    checkOutput("b_queue_empty", 32'(exp_q_b.size()), 32'd0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
